chmod_combiner: RTL and testbench



---
 rtl/chmod_pkg.sv | 44 ++++
 rtl/chmod_round_sat.sv | 38 +++
 rtl/chmod_combiner.sv | 207 ++++++++++++++++++++
 tb/tb_chmod_combiner.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chmod_pkg.sv
// chmod_pkg
//   Shared definitions for the chmod processing stages.
//   - chmod_state_t     : control FSM states
//   - MAX_SUM_LOG2_DEF  : default largest group size exponent
//   - sat_round_shift() : rounding arithmetic right shift followed by
//                         saturation to an out_w-bit two's complement range
package chmod_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } chmod_state_t;

  localparam int MAX_SUM_LOG2_DEF = 11;

  // Working width of sat_round_shift. Wide enough for any accumulator plus
  // the rounding constant, so the add can never overflow.
  localparam int SRS_W = 40;

  // Adds half an LSB of the result before the arithmetic shift, so ties
  // round toward +inf. The shifted value is then clamped to out_w bits.
  // The result is returned sign-extended to SRS_W bits.
  function automatic logic signed [SRS_W-1:0] sat_round_shift(
    input logic signed [SRS_W-1:0] acc,
    input logic        [3:0]       shift,
    input int                      out_w
  );
    logic signed [SRS_W-1:0] v_round;
    logic signed [SRS_W-1:0] v_shifted;
    logic signed [SRS_W-1:0] v_max;
    logic signed [SRS_W-1:0] v_min;
    v_round   = (shift == 4'd0) ? '0 : (SRS_W'(1) <<< (shift - 4'd1));
    v_shifted = (acc + v_round) >>> shift;
    v_max     = (SRS_W'(1) <<< (out_w - 1)) - SRS_W'(1);
    v_min     = -v_max - SRS_W'(1);
    if (v_shifted > v_max) begin
      return v_max;
    end else if (v_shifted < v_min) begin
      return v_min;
    end
    return v_shifted;
  endfunction

endpackage

// File: rtl/chmod_round_sat.sv
// chmod_round_sat
//   One output-register rail: rounds, shifts and saturates a group sum.
//   The result is registered when i_load is high and held otherwise.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset (clears o_data)
//   i_load           : capture a new result this cycle
//   i_sum            : group sum, ACC_WIDTH signed
//   i_shift          : shift amount k associated with i_sum
//   o_data           : registered WIDTH-bit signed average
module chmod_round_sat
  import chmod_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 27
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_load,
  input  logic signed [ACC_WIDTH-1:0] i_sum,
  input  logic        [3:0]           i_shift,
  output logic signed [WIDTH-1:0]     o_data
);

  logic signed [SRS_W-1:0] w_sum_wide;
  logic signed [SRS_W-1:0] w_result;

  assign w_sum_wide = SRS_W'(i_sum);
  assign w_result   = sat_round_shift(w_sum_wide, i_shift, WIDTH);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data <= '0;
    end else if (i_load) begin
      o_data <= w_result[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/chmod_combiner.sv
// chmod_combiner
//   Averages groups of 2^k consecutive I/Q samples. Samples are summed into
//   ACC_WIDTH accumulators; the completed sum (stage 1, sum_reg) is rounded,
//   shifted by k and saturated into the output register (stage 2). Two
//   completed groups can be held under output backpressure.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_INIT | one cycle after reset, input not accepted
//   ST_RUN  | normal accumulate / output operation
//
// Ports:
//   i_clock, i_reset        : clock, synchronous active-high reset
//   i_inph, i_quad, i_valid : input sample and valid
//   o_ready                 : input accepted this cycle
//   i_sum_log2(_valid)      : requested k and its capture strobe
//   o_inph, o_quad, o_valid : averaged output sample and valid
//   i_ready                 : downstream accepts output
module chmod_combiner
  import chmod_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int MAX_SUM_LOG2 = MAX_SUM_LOG2_DEF,
  parameter int ACC_WIDTH    = WIDTH + MAX_SUM_LOG2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_inph,
  input  logic signed [WIDTH-1:0] i_quad,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic        [3:0]       i_sum_log2,
  input  logic                    i_sum_log2_valid,
  output logic signed [WIDTH-1:0] o_inph,
  output logic signed [WIDTH-1:0] o_quad,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int CW = MAX_SUM_LOG2 + 1;

  chmod_state_t r_state;
  chmod_state_t w_state_next;

  logic [3:0]                  r_k;
  logic [3:0]                  r_k_pend;
  logic                        r_k_pend_valid;
  logic [3:0]                  w_k_req;
  logic                        w_k_apply;

  logic [MAX_SUM_LOG2-1:0]     r_count;
  logic [CW-1:0]               w_grp_last;
  logic                        w_last;

  logic signed [ACC_WIDTH-1:0] r_acc_i;
  logic signed [ACC_WIDTH-1:0] r_acc_q;
  logic signed [ACC_WIDTH-1:0] w_acc_next_i;
  logic signed [ACC_WIDTH-1:0] w_acc_next_q;

  logic signed [ACC_WIDTH-1:0] r_sum_i;
  logic signed [ACC_WIDTH-1:0] r_sum_q;
  logic        [3:0]           r_sum_k;
  logic                        r_sum_valid;

  logic                        r_out_valid;
  logic                        w_stage2_load;
  logic                        w_accept;
  logic                        w_final;

  // r_k never exceeds MAX_SUM_LOG2, so 2^k fits in CW bits.
  assign w_grp_last = (CW'(1) << r_k) - CW'(1);
  assign w_last     = ({1'b0, r_count} == w_grp_last);

  assign w_k_req = (i_sum_log2 > 4'(MAX_SUM_LOG2)) ? 4'(MAX_SUM_LOG2) : i_sum_log2;

  assign w_acc_next_i = r_acc_i + ACC_WIDTH'(i_inph);
  assign w_acc_next_q = r_acc_q + ACC_WIDTH'(i_quad);

  assign w_stage2_load = r_sum_valid && (!r_out_valid || i_ready);
  assign w_accept      = i_valid && o_ready;
  assign w_final       = w_accept && w_last;

  // A pending k is only taken at a group boundary: either right as the
  // final sample lands, or while idle at count 0 with nothing arriving.
  assign w_k_apply = r_k_pend_valid &&
                     (w_final || ((r_count == '0) && !w_accept));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // o_ready depends combinationally on i_ready through w_stage2_load: a
  // final sample can enter sum_reg in the same cycle its old contents move
  // to the output register.
  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        o_ready = !(w_last && r_sum_valid && !w_stage2_load);
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
      r_acc_i <= '0;
      r_acc_q <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_count <= '0;
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else begin
        r_count <= r_count + 1'b1;
        r_acc_i <= w_acc_next_i;
        r_acc_q <= w_acc_next_q;
      end
    end
  end

  // sum_reg carries its own k so a later config change cannot affect how a
  // completed group is scaled.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sum_i     <= '0;
      r_sum_q     <= '0;
      r_sum_k     <= '0;
      r_sum_valid <= 1'b0;
    end else if (w_final) begin
      r_sum_i     <= w_acc_next_i;
      r_sum_q     <= w_acc_next_q;
      r_sum_k     <= r_k;
      r_sum_valid <= 1'b1;
    end else if (w_stage2_load) begin
      r_sum_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
    end else if (w_stage2_load) begin
      r_out_valid <= 1'b1;
    end else if (i_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A strobe in the same cycle as an apply takes effect on the old pending
  // value and leaves the new one pending; the newest strobe always wins.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_k            <= '0;
      r_k_pend       <= '0;
      r_k_pend_valid <= 1'b0;
    end else begin
      if (w_k_apply) begin
        r_k <= r_k_pend;
      end
      if (i_sum_log2_valid) begin
        r_k_pend       <= w_k_req;
        r_k_pend_valid <= 1'b1;
      end else if (w_k_apply) begin
        r_k_pend_valid <= 1'b0;
      end
    end
  end

  chmod_round_sat #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_rs_inph (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_stage2_load),
    .i_sum   (r_sum_i),
    .i_shift (r_sum_k),
    .o_data  (o_inph)
  );

  chmod_round_sat #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_rs_quad (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_stage2_load),
    .i_sum   (r_sum_q),
    .i_shift (r_sum_k),
    .o_data  (o_quad)
  );

  assign o_valid = r_out_valid;

endmodule

// File: tb/tb_chmod_combiner.sv
module tb_chmod_combiner;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic signed [15:0] i_inph;
  logic signed [15:0] i_quad;
  logic               i_valid;
  logic               o_ready;
  logic        [3:0]  i_sum_log2;
  logic               i_sum_log2_valid;
  logic signed [15:0] o_inph;
  logic signed [15:0] o_quad;
  logic               o_valid;
  logic               i_ready;

  chmod_combiner dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_inph           (i_inph),
    .i_quad           (i_quad),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_sum_log2       (i_sum_log2),
    .i_sum_log2_valid (i_sum_log2_valid),
    .o_inph           (o_inph),
    .o_quad           (o_quad),
    .o_valid          (o_valid),
    .i_ready          (i_ready)
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int i;
    int q;
  } samp_t;

  samp_t outq[$];

  // Output transfers happen on the next rising edge; record them once here.
  always @(negedge i_clock) begin
    if (o_valid && i_ready) begin
      outq.push_back('{int'(o_inph), int'(o_quad)});
    end
  end

  typedef struct packed {
    logic [3:0]       k;
    logic [3:0][15:0] si;
    logic [3:0][15:0] sq;
    logic [15:0]      ei;
    logic [15:0]      eq;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input int k,
                              input int i0, input int i1, input int i2, input int i3,
                              input int q0, input int q1, input int q2, input int q3,
                              input int ei, input int eq);
    vec_t m;
    m.k  = 4'(k);
    m.si = {16'(i3), 16'(i2), 16'(i1), 16'(i0)};
    m.sq = {16'(q3), 16'(q2), 16'(q1), 16'(q0)};
    m.ei = 16'(ei);
    m.eq = 16'(eq);
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send(input int si, input int sq);
    int   guard;
    logic ok;
    i_inph  = 16'(si);
    i_quad  = 16'(sq);
    i_valid = 1'b1;
    guard   = 0;
    do begin
      @(negedge i_clock);
      ok = o_ready;
      @(posedge i_clock);
      #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) chk("send_timeout", int'(ok), 1);
    i_valid = 1'b0;
  endtask

  task automatic strobe(input int v);
    i_sum_log2       = 4'(v);
    i_sum_log2_valid = 1'b1;
    @(posedge i_clock);
    #1;
    i_sum_log2_valid = 1'b0;
  endtask

  task automatic set_k(input int v);
    strobe(v);
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk_queue(input string nm, input int idx, input int ei, input int eq);
    if (idx < outq.size()) begin
      chk({nm, "_i"}, outq[idx].i, ei);
      chk({nm, "_q"}, outq[idx].q, eq);
    end else begin
      chk({nm, "_present"}, outq.size(), idx + 1);
    end
  endtask

  int bp_ei[5] = '{5, 25, 45, 65, 85};
  int bp_eq[5] = '{0, -2, -4, -6, -8};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cur_k;
    int   n;
    int   stall_at;
    logic acc_ok;

    vecs[0]  = mk(0,      7,     0,     0,     0,     -7,      0,      0,      0,      7,     -7);
    vecs[1]  = mk(0,  32767,     0,     0,     0,     -1,      0,      0,      0,  32767,     -1);
    vecs[2]  = mk(0,     -1,     0,     0,     0,      1,      0,      0,      0,     -1,      1);
    vecs[3]  = mk(1,      1,     2,     0,     0,     -1,     -2,      0,      0,      2,     -1);
    vecs[4]  = mk(1,      3,    -4,     0,     0,     -3,      0,      0,      0,      0,     -1);
    vecs[5]  = mk(1,  32767, 32767,     0,     0, -32768, -32768,      0,      0,  32767, -32768);
    vecs[6]  = mk(1,     -5,    -6,     0,     0,      5,      6,      0,      0,     -5,      6);
    vecs[7]  = mk(2,      1,     2,     3,     4,     -1,     -1,     -1,     -2,      3,     -1);
    vecs[8]  = mk(2,      1,     0,     0,     0,      2,      0,      0,      0,      0,      1);
    vecs[9]  = mk(2,     -2,     0,     0,     0,     -3,      0,      0,      0,      0,     -1);
    vecs[10] = mk(2,  32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768,  32767, -32768);

    i_reset          = 1'b1;
    i_inph           = '0;
    i_quad           = '0;
    i_valid          = 1'b0;
    i_sum_log2       = '0;
    i_sum_log2_valid = 1'b0;
    i_ready          = 1'b1;

    // Reset and the single ST_INIT cycle
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    chk("rst_o_ready", int'(o_ready), 0);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_inph",  int'(o_inph),  0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("init_o_ready", int'(o_ready), 0);
    chk("init_o_valid", int'(o_valid), 0);
    @(posedge i_clock);
    #1;
    @(negedge i_clock);
    chk("run_o_ready", int'(o_ready), 1);
    @(posedge i_clock);
    #1;
    cur_k = 0;

    // k=0 passthrough, back-to-back, latency 2
    outq.delete();
    i_inph  = 16'sd100;
    i_quad  = -16'sd5;
    i_valid = 1'b1;
    @(negedge i_clock);
    chk("pt_ready_a", int'(o_ready), 1);
    @(posedge i_clock);
    #1;
    i_inph = 16'sh8000;
    i_quad = 16'sh7fff;
    @(negedge i_clock);
    chk("pt_t1_valid", int'(o_valid), 0);
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    @(negedge i_clock);
    chk("pt_t2_valid", int'(o_valid), 1);
    chk("pt_a_i", int'(o_inph), 100);
    chk("pt_a_q", int'(o_quad), -5);
    @(posedge i_clock);
    #1;
    @(negedge i_clock);
    chk("pt_t3_valid", int'(o_valid), 1);
    chk("pt_b_i", int'(o_inph), -32768);
    chk("pt_b_q", int'(o_quad), 32767);
    @(posedge i_clock);
    #1;
    @(negedge i_clock);
    chk("pt_drain_valid", int'(o_valid), 0);
    chk("pt_count", outq.size(), 2);
    @(posedge i_clock);
    #1;

    // Table of single groups with hand-computed averages
    for (int v = 0; v < 11; v++) begin
      if (int'(vecs[v].k) != cur_k) begin
        set_k(int'(vecs[v].k));
        cur_k = int'(vecs[v].k);
      end
      outq.delete();
      for (int j = 0; j < (1 << vecs[v].k); j++) begin
        send(int'($signed(vecs[v].si[j])), int'($signed(vecs[v].sq[j])));
      end
      @(negedge i_clock);
      chk($sformatf("vec%0d_lat1_valid", v), int'(o_valid), 0);
      @(negedge i_clock);
      chk($sformatf("vec%0d_lat2_valid", v), int'(o_valid), 1);
      @(posedge i_clock);
      #1;
      repeat (3) @(posedge i_clock);
      #1;
      chk($sformatf("vec%0d_count", v), outq.size(), 1);
      chk_queue($sformatf("vec%0d", v), 0,
                int'($signed(vecs[v].ei)), int'($signed(vecs[v].eq)));
    end

    // k=11 via an out-of-range request (clamped), full-scale inputs
    set_k(15);
    outq.delete();
    for (int j = 0; j < 2047; j++) send(32767, -32768);
    repeat (3) @(posedge i_clock);
    #1;
    chk("k11_no_early_out", outq.size(), 0);
    send(32767, -32768);
    repeat (5) @(posedge i_clock);
    #1;
    chk("k11_count", outq.size(), 1);
    chk_queue("k11", 0, 32767, -32768);

    // Backpressure with k=1: two groups held, stall on third final sample
    set_k(1);
    outq.delete();
    i_ready  = 1'b0;
    n        = 0;
    stall_at = -1;
    for (int c = 0; c < 60 && n < 10; c++) begin
      if (c == 10) i_ready = 1'b1;
      i_inph  = 16'(10 * n);
      i_quad  = 16'(-n);
      i_valid = 1'b1;
      @(negedge i_clock);
      acc_ok = o_ready;
      if (!o_ready && stall_at < 0) stall_at = n;
      if (c == 9) begin
        chk("bp_hold_valid", int'(o_valid), 1);
        chk("bp_hold_i", int'(o_inph), 5);
        chk("bp_hold_q", int'(o_quad), 0);
        chk("bp_stalled", int'(o_ready), 0);
      end
      @(posedge i_clock);
      #1;
      if (acc_ok) n++;
    end
    i_valid = 1'b0;
    chk("bp_stall_index", stall_at, 5);
    chk("bp_sent", n, 10);
    repeat (8) @(posedge i_clock);
    #1;
    chk("bp_count", outq.size(), 5);
    for (int g = 0; g < 5; g++) chk_queue($sformatf("bp_g%0d", g), g, bp_ei[g], bp_eq[g]);

    // Config change mid-group: two strobes, the last (k=1) wins
    set_k(2);
    outq.delete();
    send(1, 0);
    strobe(3);
    strobe(1);
    for (int j = 1; j < 8; j++) send(j + 1, 4 * j);
    repeat (5) @(posedge i_clock);
    #1;
    chk("cfg_count", outq.size(), 3);
    chk_queue("cfg_g0", 0, 3, 6);
    chk_queue("cfg_g1", 1, 6, 18);
    chk_queue("cfg_g2", 2, 8, 26);

    // Reset mid-operation discards partial group and held output
    i_ready = 1'b0;
    send(50, 50);
    send(60, 60);
    send(70, 70);
    @(posedge i_clock);
    #1;
    chk("rmid_held_valid", int'(o_valid), 1);
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    i_ready = 1'b1;
    outq.delete();
    @(negedge i_clock);
    chk("rmid_valid_cleared", int'(o_valid), 0);
    @(posedge i_clock);
    #1;
    send(-9, 9);
    repeat (4) @(posedge i_clock);
    #1;
    chk("rmid_count", outq.size(), 1);
    chk_queue("rmid", 0, -9, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
